traffic_phase_scheduler: RTL and testbench

Demand-driven phase scheduler for a four-way intersection (N, S, E, W). It latches vehicle-detector requests and grants green to one approach at a time in round-robin order, skipping approaches with no demand. Green time is extended while the served approach stays occupied, up to a maximum. Each green ends with yellow and then an all-red clearance. It drives the four 3-bit signal heads directly and replaces the fixed-rotation sequencer.

---
 rtl/traffic_phase_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-way intersection.
// Define PED_WALK_EN to add the pedestrian WALK phase (ped_req / walk ports).
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] car_req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] n_light,
  output logic [2:0] s_light,
  output logic [2:0] e_light,
  output logic [2:0] w_light,
  output logic [1:0] grant_dir,
  output logic [1:0] phase
);

  localparam logic [2:0] LIGHT_RED    = 3'b000;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3
`ifdef PED_WALK_EN
    , ST_WALK = 3'd4
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       grant_reg, grant_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [3:0]       pend_reg, pend_next;
  logic [3:0]       pend_rot;
  logic [1:0]       next_off;
  logic [1:0]       next_dir;
  logic             other_pend;
  logic [3:0][2:0]  head_reg, head_next;
  logic [1:0]       phase_reg, phase_next;
`ifdef PED_WALK_EN
  logic             ped_pend_reg, ped_pend_next;
  logic             walk_reg, walk_next;
`endif

  // pend_rot[k] is the request k+1 positions after the current grant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign pend_rot[gi] = pend_reg[grant_reg + 2'(gi + 1)];
    end
  endgenerate

  always_comb begin
    next_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_rot[i]) next_off = 2'(i);
    end
  end

  assign next_dir   = grant_reg + next_off + 2'd1;
  assign other_pend = |(pend_reg & ~(4'b0001 << grant_reg));

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    timer_next = timer_reg + 1'b1;
    pend_next  = pend_reg | car_req;
`ifdef PED_WALK_EN
    ped_pend_next = ped_pend_reg | ped_req;
`endif
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
`ifdef PED_WALK_EN
        if (ped_pend_reg) begin
          state_next    = ST_WALK;
          ped_pend_next = 1'b0;
        end else
`endif
        if (|pend_reg) begin
          state_next          = ST_GREEN;
          grant_next          = next_dir;
          pend_next[next_dir] = 1'b0;
        end
      end
      ST_GREEN: begin
        if ((timer_reg == MAX_LAST) ||
            ((timer_reg >= MIN_LAST) && (!car_req[grant_reg] || other_pend))) begin
          state_next = ST_YELLOW;
          timer_next = '0;
        end
      end
      ST_YELLOW: begin
        if (timer_reg == YEL_LAST) begin
          state_next = ST_ALLRED;
          timer_next = '0;
        end
      end
      ST_ALLRED: begin
        if (timer_reg == AR_LAST) begin
          timer_next = '0;
          state_next = ST_IDLE;
`ifdef PED_WALK_EN
          // A waiting pedestrian wins over vehicle demand at clearance end.
          if (ped_pend_reg) begin
            state_next    = ST_WALK;
            ped_pend_next = 1'b0;
          end else
`endif
          if (|pend_reg) begin
            state_next          = ST_GREEN;
            grant_next          = next_dir;
            pend_next[next_dir] = 1'b0;
          end
        end
      end
`ifdef PED_WALK_EN
      ST_WALK: begin
        if (timer_reg == MIN_LAST) begin
          state_next = ST_ALLRED;
          timer_next = '0;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_head
      assign head_next[gi] = (grant_next != 2'(gi))      ? LIGHT_RED    :
                             (state_next == ST_GREEN)    ? LIGHT_GREEN  :
                             (state_next == ST_YELLOW)   ? LIGHT_YELLOW :
                                                           LIGHT_RED;
    end
  endgenerate

  always_comb begin
    phase_next = 2'd0;
    case (state_next)
      ST_GREEN:  phase_next = 2'd1;
      ST_YELLOW: phase_next = 2'd2;
      ST_ALLRED: phase_next = 2'd3;
      default:   phase_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_reg <= ST_IDLE;
      grant_reg <= 2'd3;
      timer_reg <= '0;
      pend_reg  <= '0;
      head_reg  <= '0;
      phase_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      timer_reg <= timer_next;
      pend_reg  <= pend_next;
      head_reg  <= head_next;
      phase_reg <= phase_next;
    end
  end

`ifdef PED_WALK_EN
  assign walk_next = (state_next == ST_WALK);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ped_pend_reg <= 1'b0;
      walk_reg     <= 1'b0;
    end else begin
      ped_pend_reg <= ped_pend_next;
      walk_reg     <= walk_next;
    end
  end

  assign walk = walk_reg;
`endif

  assign n_light   = head_reg[0];
  assign s_light   = head_reg[1];
  assign e_light   = head_reg[2];
  assign w_light   = head_reg[3];
  assign grant_dir = grant_reg;
  assign phase     = phase_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected light segments
// (kind, approach, length) are queued with the stimulus and checked as they end.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic [3:0] car_req = 4'd0;
  logic [2:0] n_light, s_light, e_light, w_light;
  logic [1:0] grant_dir, phase;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  // kind: 0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED, 4 WALK; len 0 = any length
  typedef struct {
    int kind;
    int dir;
    int len;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_kind = 0;
  int   cur_dir = 3;
  int   run_len = 0;
  bit   track_en = 1'b0;
  logic walk_s;

  traffic_phase_scheduler dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .car_req   (car_req),
`ifdef PED_WALK_EN
    .ped_req   (ped_req),
    .walk      (walk),
`endif
    .n_light   (n_light),
    .s_light   (s_light),
    .e_light   (e_light),
    .w_light   (w_light),
    .grant_dir (grant_dir),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_seg(input int k, input int d, input int l);
    seg_t s;
    s.kind = k;
    s.dir  = d;
    s.len  = l;
    exp_q.push_back(s);
  endtask

  // Monitor: samples on the falling edge, checks head consistency every
  // cycle, and scores each completed segment against the queue.
  task automatic step();
    logic [3:0][2:0] act_h;
    logic [3:0][2:0] exp_h;
    int kind;
    seg_t e;
    @(negedge clk);
`ifdef PED_WALK_EN
    walk_s = walk;
`else
    walk_s = 1'b0;
`endif
    act_h = {w_light, e_light, s_light, n_light};
    for (int i = 0; i < 4; i++) begin
      exp_h[i] = 3'b000;
      if (!walk_s && grant_dir == 2'(i)) begin
        if (phase == 2'd1) exp_h[i] = 3'b001;
        else if (phase == 2'd2) exp_h[i] = 3'b010;
      end
    end
    checks++;
    if (act_h !== exp_h || (walk_s === 1'b1 && phase !== 2'd0)) begin
      failures++;
      $display("FAIL heads: got heads(WESN)=%h phase=%0d grant=%0d walk=%0b, required heads=%h",
               act_h, phase, grant_dir, walk_s, exp_h);
    end
    if (track_en) begin
      kind = walk_s ? 4 : int'(phase);
      if (kind == cur_kind && int'(grant_dir) == cur_dir) begin
        run_len++;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL segment: got kind=%0d dir=%0d len=%0d, required no further segment",
                   cur_kind, cur_dir, run_len);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != cur_kind || e.dir != cur_dir || (e.len != 0 && e.len != run_len)) begin
            failures++;
            $display("FAIL segment: got kind=%0d dir=%0d len=%0d, required kind=%0d dir=%0d len=%0d",
                     cur_kind, cur_dir, run_len, e.kind, e.dir, e.len);
          end else begin
            $display("segment kind=%0d dir=%0d len=%0d ok", cur_kind, cur_dir, run_len);
          end
        end
        cur_kind = kind;
        cur_dir  = int'(grant_dir);
        run_len  = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_a    = 1'b1;
    car_req  = 4'd0;
`ifdef PED_WALK_EN
    ped_req  = 1'b0;
`endif
    track_en = 1'b0;
    repeat (2) step();
    rst_a    = 1'b0;
    exp_q.delete();
    cur_kind = 0;
    cur_dir  = 3;
    run_len  = 0;
    track_en = 1'b1;
  endtask

  task automatic test_reset();
    logic w;
    rst_a = 1'b1;
    car_req = 4'd0;
    track_en = 1'b0;
    step();
`ifdef PED_WALK_EN
    w = walk;
`else
    w = 1'b0;
`endif
    checks++;
    if ({n_light, s_light, e_light, w_light} !== 12'd0 || phase !== 2'd0 ||
        grant_dir !== 2'd3 || w !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got lights=%h phase=%0d grant=%0d walk=%0b, required 000 0 3 0",
               {n_light, s_light, e_light, w_light}, phase, grant_dir, w);
    end else $display("reset_hold ok");
    rst_a = 1'b0;
    repeat (3) step();
    checks++;
    if ({n_light, s_light, e_light, w_light} !== 12'd0 || phase !== 2'd0 || grant_dir !== 2'd3) begin
      failures++;
      $display("FAIL reset_idle: got lights=%h phase=%0d grant=%0d, required 000 0 3",
               {n_light, s_light, e_light, w_light}, phase, grant_dir);
    end else $display("reset_idle ok");
  endtask

  task automatic test_single_pulse();
    do_reset();
    push_seg(0, 3, 0);
    push_seg(1, 0, 4);
    push_seg(2, 0, 3);
    push_seg(3, 0, 1);
    push_seg(0, 0, 0);
    car_req = 4'b0001;
    step();
    car_req = 4'b0000;
    repeat (14) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 0) begin
      failures++;
      $display("FAIL single_end: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=0",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask

  task automatic test_hold_max();
    do_reset();
    push_seg(0, 3, 0);
    push_seg(1, 0, 12);
    push_seg(2, 0, 3);
    push_seg(3, 0, 1);
    push_seg(1, 0, 4);
    push_seg(2, 0, 3);
    push_seg(3, 0, 1);
    push_seg(0, 0, 0);
    car_req = 4'b0001;
    repeat (18) step();
    car_req = 4'b0000;
    repeat (12) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 0) begin
      failures++;
      $display("FAIL hold_end: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=0",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    do_reset();
    push_seg(0, 3, 0);
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        push_seg(1, d, 4);
        push_seg(2, d, 3);
        push_seg(3, d, 1);
      end
    end
    push_seg(0, 3, 0);
    car_req = 4'b1111;
    repeat (34) step();
    car_req = 4'b0000;
    repeat (36) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 3) begin
      failures++;
      $display("FAIL rr_end: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=3",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask

  task automatic test_extend_preempt();
    do_reset();
    push_seg(0, 3, 0);
    push_seg(1, 0, 7);
    push_seg(2, 0, 3);
    push_seg(3, 0, 1);
    push_seg(1, 2, 4);
    push_seg(2, 2, 3);
    push_seg(3, 2, 1);
    push_seg(1, 0, 4);
    push_seg(2, 0, 3);
    push_seg(3, 0, 1);
    push_seg(0, 0, 0);
    car_req = 4'b0001;
    repeat (7) step();
    car_req = 4'b0101;
    step();
    car_req = 4'b0001;
    repeat (2) step();
    car_req = 4'b0000;
    repeat (25) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 0) begin
      failures++;
      $display("FAIL preempt_end: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=0",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_green();
    do_reset();
    push_seg(0, 3, 0);
    push_seg(1, 0, 3);
    car_req = 4'b0001;
    repeat (4) step();
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({n_light, s_light, e_light, w_light} !== 12'd0 || phase !== 2'd0 || grant_dir !== 2'd3) begin
      failures++;
      $display("FAIL async_reset: got lights=%h phase=%0d grant=%0d, required 000 0 3",
               {n_light, s_light, e_light, w_light}, phase, grant_dir);
    end else $display("async_reset ok");
    push_seg(0, 3, 0);
    car_req = 4'b0000;
    repeat (2) step();
    rst_a = 1'b0;
    repeat (6) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 3) begin
      failures++;
      $display("FAIL reset_pend: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=3",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask

`ifdef PED_WALK_EN
  task automatic test_ped_walk();
    do_reset();
    push_seg(0, 3, 0);
    push_seg(1, 1, 4);
    push_seg(2, 1, 3);
    push_seg(3, 1, 1);
    push_seg(4, 1, 4);
    push_seg(3, 1, 1);
    push_seg(1, 2, 4);
    push_seg(2, 2, 3);
    push_seg(3, 2, 1);
    push_seg(0, 2, 0);
    car_req = 4'b0110;
    step();
    car_req = 4'b0000;
    repeat (2) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    repeat (26) step();
    checks++;
    if (exp_q.size() != 1 || cur_kind != 0 || cur_dir != 2) begin
      failures++;
      $display("FAIL ped_end: got left=%0d kind=%0d dir=%0d, required left=1 kind=0 dir=2",
               exp_q.size(), cur_kind, cur_dir);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_hold_max();
    test_round_robin();
    test_extend_preempt();
    test_reset_mid_green();
`ifdef PED_WALK_EN
    test_ped_walk();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
